// File: rtl/mac_rx_pkt_checker_if.sv
// AXI4-Stream bundle carrying MAC RX beats into the traffic checker.
// The master drives the beat; the slave returns tready.
interface mac_rx_pkt_checker_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/mac_rx_pkt_checker.sv
// Receive-side traffic checker: compares RX beats with the generator pattern,
// counts packets/bytes/bit errors and reports a 5-bit completion status.
module mac_rx_pkt_checker #(
    parameter int unsigned DRAIN_CYC    = 1024,
    parameter int unsigned LOCK_TIMEOUT = 2**20,
    parameter int unsigned RUN_TIMEOUT  = 2**24
) (
    input  logic                        rx_clk,
    input  logic                        sys_reset,
    mac_rx_pkt_checker_if.slave         s_axis,
    input  logic                        rx_block_lock,
    input  logic                        tx_done,
    input  logic [31:0]                 tx_pkt_cnt,
    input  logic [47:0]                 tx_byte_cnt,
    output logic [31:0]                 rx_pkt_cnt,
    output logic [47:0]                 rx_byte_cnt,
    output logic [31:0]                 bit_err_cnt,
    output logic [4:0]                  completion_status
);

    typedef enum logic [2:0] {
        ST_RESET, ST_WAIT_LOCK, ST_RUN, ST_DRAIN, ST_COMPARE, ST_DONE
    } state_t;

    localparam logic [4:0] STS_RESET     = 5'h1F;
    localparam logic [4:0] STS_BUSY      = 5'd0;
    localparam logic [4:0] STS_PASS      = 5'd1;
    localparam logic [4:0] STS_LOCK_TO   = 5'd2;
    localparam logic [4:0] STS_LOCK_LOST = 5'd4;
    localparam logic [4:0] STS_RUN_TO    = 5'd10;
    localparam logic [4:0] STS_NO_TX     = 5'd11;
    localparam logic [4:0] STS_PKT_MIS   = 5'd12;
    localparam logic [4:0] STS_BYTE_MIS  = 5'd13;
    localparam logic [4:0] STS_PROTO     = 5'd14;
    localparam logic [4:0] STS_BIT_ERR   = 5'd15;

    function automatic logic [6:0] popcnt64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + 7'(v[i]);
        return n;
    endfunction

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_status, w_status_nxt;
    logic [31:0] r_timer;

    logic [31:0] r_rx_pkt_cnt;
    logic [47:0] r_rx_byte_cnt;
    logic [31:0] r_bit_err_cnt;
    logic [15:0] r_beat;
    logic        r_proto_err;
    logic [63:0] r_err_mask;
    logic        r_err_vld;

    logic        w_tready;
    logic        w_accept;
    logic [63:0] w_byte_mask;
    logic [63:0] w_expected;
    logic        w_keep_contig;
    logic        w_proto_bad;
    logic [32:0] w_err_sum;

    // Lock loss blocks acceptance in the same cycle it is observed.
    assign w_tready      = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && rx_block_lock;
    assign s_axis.tready = w_tready;
    assign w_accept      = s_axis.tvalid && w_tready;

    assign w_expected    = {r_rx_pkt_cnt[15:0], r_beat, ~r_rx_pkt_cnt[15:0], ~r_beat};
    assign w_keep_contig = (s_axis.tkeep != 8'h00) &&
                           ((s_axis.tkeep & (s_axis.tkeep + 8'd1)) == 8'h00);
    assign w_proto_bad   = s_axis.tlast ? (!w_keep_contig || s_axis.tuser)
                                        : (s_axis.tkeep != 8'hFF);
    assign w_err_sum     = {1'b0, r_bit_err_cnt} + 33'(popcnt64(r_err_mask));

    always_comb begin
        w_byte_mask = '0;
        for (int i = 0; i < 8; i++) w_byte_mask[8*i +: 8] = {8{s_axis.tkeep[i]}};
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        case (r_state)
            ST_RESET: begin
                w_state_nxt  = ST_WAIT_LOCK;
                w_status_nxt = STS_BUSY;
            end
            ST_WAIT_LOCK: begin
                if (rx_block_lock) begin
                    w_state_nxt = ST_RUN;
                end else if (r_timer == 32'(LOCK_TIMEOUT - 1)) begin
                    w_state_nxt  = ST_DONE;
                    w_status_nxt = STS_LOCK_TO;
                end
            end
            ST_RUN: begin
                if (!rx_block_lock) begin
                    w_state_nxt  = ST_DONE;
                    w_status_nxt = STS_LOCK_LOST;
                end else if (tx_done) begin
                    w_state_nxt = ST_DRAIN;
                end else if (r_timer == 32'(RUN_TIMEOUT - 1)) begin
                    w_state_nxt  = ST_DONE;
                    w_status_nxt = STS_RUN_TO;
                end
            end
            ST_DRAIN: begin
                if (!rx_block_lock) begin
                    w_state_nxt  = ST_DONE;
                    w_status_nxt = STS_LOCK_LOST;
                end else if (r_timer == 32'(DRAIN_CYC - 1)) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                w_state_nxt = ST_DONE;
                if (tx_pkt_cnt == 32'd0)                w_status_nxt = STS_NO_TX;
                else if (r_rx_pkt_cnt != tx_pkt_cnt)    w_status_nxt = STS_PKT_MIS;
                else if (r_rx_byte_cnt != tx_byte_cnt)  w_status_nxt = STS_BYTE_MIS;
                else if (r_proto_err)                   w_status_nxt = STS_PROTO;
                else if (r_bit_err_cnt != 32'd0)        w_status_nxt = STS_BIT_ERR;
                else                                    w_status_nxt = STS_PASS;
            end
            ST_DONE: ;
            default: w_state_nxt = ST_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rx_clk) begin
        if (sys_reset) begin
            r_state  <= ST_RESET;
            r_status <= STS_RESET;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_timer  <= (w_state_nxt != r_state) ? 32'd0 : r_timer + 32'd1;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (sys_reset) begin
            r_rx_pkt_cnt  <= '0;
            r_rx_byte_cnt <= '0;
            r_bit_err_cnt <= '0;
            r_beat        <= '0;
            r_proto_err   <= 1'b0;
            r_err_vld     <= 1'b0;
        end else begin
            r_err_vld <= w_accept;
            if (w_accept) begin
                r_rx_pkt_cnt  <= r_rx_pkt_cnt + 32'(s_axis.tlast);
                r_rx_byte_cnt <= r_rx_byte_cnt + 48'(popcnt8(s_axis.tkeep));
                r_beat        <= s_axis.tlast ? 16'd0 : r_beat + 16'd1;
                if (w_proto_bad) r_proto_err <= 1'b1;
            end
            if (r_err_vld)
                r_bit_err_cnt <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
        end
    end

    // NOTE: the mask stage has no reset; it is only consumed when r_err_vld is set.
    always_ff @(posedge rx_clk) begin
        if (w_accept) r_err_mask <= (s_axis.tdata ^ w_expected) & w_byte_mask;
    end

    assign rx_pkt_cnt        = r_rx_pkt_cnt;
    assign rx_byte_cnt       = r_rx_byte_cnt;
    assign bit_err_cnt       = r_bit_err_cnt;
    assign completion_status = r_status;

endmodule

// File: doc/mac_rx_pkt_checker.md
# mac_rx_pkt_checker

Receive-side traffic checker for the 25GE QSFP MAC datapath. Consumes the MAC RX AXI4-Stream, checks every beat against the deterministic payload pattern emitted by the TX generator, counts packets, bytes and bit errors, and reports a 5-bit `completion_status` using the same encoding the system testbench decodes. Sits between the MAC RX user interface and the top-level status/LED logic, on the MAC RX user clock.

## Interface
- `DRAIN_CYC`, 1024: cycles to keep receiving after `tx_done` before final compare.
- `LOCK_TIMEOUT`, 2**20: cycles allowed from reset release to `rx_block_lock`.
- `RUN_TIMEOUT`, 2**24: cycles allowed from lock to `tx_done`.

- `rx_clk` in 1: MAC RX user clock; all logic on rising edge.
- `sys_reset` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 64: RX beat data.
- `s_axis_tkeep` in 8: byte enables, bit i = byte i (bits [8i+7:8i]).
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tlast` in 1: last beat of packet.
- `s_axis_tuser` in 1: MAC-flagged bad frame, sampled on tlast beat.
- `s_axis_tready` out 1: checker ready.
- `rx_block_lock` in 1: PCS block lock from MAC.
- `tx_done` in 1: generator finished; level, stays high.
- `tx_pkt_cnt` in 32: packets sent by generator, stable once `tx_done`=1.
- `tx_byte_cnt` in 48: bytes sent by generator, stable once `tx_done`=1.
- `rx_pkt_cnt` out 32: packets received (tlast beats accepted).
- `rx_byte_cnt` out 48: bytes received (sum of popcount(tkeep) on accepted beats).
- `bit_err_cnt` out 32: mismatched payload bits, saturating at 32'hFFFF_FFFF.
- `completion_status` out 5: result code.

## Operation
- Expected pattern, beat b (0-based within packet) of packet s (0-based seq): `{s[15:0], b[15:0], ~s[15:0], ~b[15:0]}`. Seq = `rx_pkt_cnt` at first beat; b resets to 0 after each tlast.
- Bit errors per accepted beat: popcount((tdata ^ expected) & byte-mask from tkeep).
- Protocol error (sticky): non-tlast beat with tkeep != 8'hFF; tlast beat with tkeep zero or non-contiguous from LSB; tuser=1 on tlast beat.
- FSM states:
  - RESET: while `sys_reset`; status 5'h1F.
  - WAIT_LOCK: status 0; tready=0; `rx_block_lock`=1 -> RUN; counter reaches LOCK_TIMEOUT -> DONE with 2.
  - RUN: tready=1; counting/checking active; `rx_block_lock` falls -> DONE with 4; `tx_done`=1 -> DRAIN; RUN_TIMEOUT cycles -> DONE with 10.
  - DRAIN: tready=1, checking continues for DRAIN_CYC cycles; lock loss -> DONE with 4; expiry -> COMPARE.
  - COMPARE (one cycle): first true, in order: tx_pkt_cnt==0 -> 11; rx_pkt_cnt!=tx_pkt_cnt -> 12; rx_byte_cnt!=tx_byte_cnt -> 13; protocol error -> 14; bit_err_cnt!=0 -> 15; else 1. -> DONE.
  - DONE: tready=0; status and counters frozen until reset.
- Counters wrap only at natural width (pkt/byte); bit_err_cnt saturates.

## Timing
- Reset values: tready 0, rx_pkt_cnt 0, rx_byte_cnt 0, bit_err_cnt 0, completion_status 5'h1F, FSM RESET.
- First cycle after reset deasserts: status 0, FSM WAIT_LOCK.
- Beat accepted when tvalid & tready. Pkt/byte counters update the cycle after acceptance.
- Bit-error path is two-stage pipelined (XOR/mask reg, popcount+accumulate reg): bit_err_cnt reflects beat N two cycles after acceptance.
- Lock loss observed the cycle it happens: status 4 visible next cycle; beats in that cycle are not accepted.
- `tx_done` rising in RUN: DRAIN entered next cycle; COMPARE exactly DRAIN_CYC cycles later; status valid the cycle after COMPARE.
- `sys_reset` mid-operation: all state returns to reset values next edge, regardless of FSM state.

## Test plan
- Reset hold 20 cycles, lock at cycle 50, 100 clean packets of 8 full beats + tlast keep 8'h0F, tx_pkt_cnt=100, tx_byte_cnt=6800 -> rx_pkt_cnt 100, rx_byte_cnt 6800, status 1.
- Same traffic, bit 5 of beat 3 in packet 42 flipped -> bit_err_cnt 1, status 15.
- Drop packet 7, tx counts unchanged -> status 12; extra byte on last beat only (keep 8'h1F, tx_byte_cnt unadjusted) -> status 13.
- Mid-packet beat with tkeep 8'hF0, counts otherwise matching -> status 14; tuser=1 on tlast -> 14.
- Never assert lock -> status 0 until LOCK_TIMEOUT, then 2; lock then drop during RUN -> 4 next cycle, tready 0.
- Lock, tx_done=1 with tx_pkt_cnt=0 -> 11 after DRAIN_CYC+1 cycles; assert sys_reset in DRAIN -> status 5'h1F and counters 0 next cycle.
